alux_sequencer: RTL and testbench

- Initiator-side sequencer for the ALUX start/done handshake. It accepts one operation descriptor at a time: operator, two source registers, a destination register and a write-back enable.
- It reads both operands from reg_bank, launches ALUX, waits for done and optionally writes the result back into reg_bank.
- It then presents the result and status to the upstream controller.
- It sits between the controller and reg_bank/ALUX, replacing manual operand/regwen sequencing.

---
 rtl/alux_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alux_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alux_sequencer.sv
// Initiator-side sequencer for the ALUX start/done handshake: reads two operands from reg_bank,
// launches ALUX, waits for done (with timeout), optionally writes back, then returns a response.
module alux_sequencer #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    // Command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opr,
    input  logic [3:0]        cmd_srcA,
    input  logic [3:0]        cmd_srcB,
    input  logic [3:0]        cmd_dst,
    input  logic              cmd_wb,
    // reg_bank read side
    output logic [3:0]        seloutA,
    output logic [3:0]        seloutB,
    output logic              enrregA,
    output logic              enrregB,
    output logic              cnstA,
    output logic              cnstB,
    input  logic [DATA_W-1:0] outA,
    input  logic [DATA_W-1:0] outB,
    // reg_bank write side
    output logic              regwen,
    output logic [3:0]        selwreg,
    output logic [1:0]        endwreg,
    output logic [DATA_W-1:0] wdata,
    // ALUX
    output logic [DATA_W-1:0] alu_inA,
    output logic [DATA_W-1:0] alu_inB,
    output logic [3:0]        alu_opr,
    output logic              alu_start,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_done,
    // Response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StStart,
        StWait,
        StWrite,
        StResp
    } state_e;

    localparam logic [2:0]  RdLast  = 3'(RD_LAT - 1);
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [3:0]          opr_q;
    logic [3:0]          src_a_q;
    logic [3:0]          src_b_q;
    logic [3:0]          dst_q;
    logic                wb_q;
    logic [2:0]          rd_cnt_q;
    logic [15:0]         tmo_cnt_q;
    logic [DATA_W-1:0]   in_a_q;
    logic [DATA_W-1:0]   in_b_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;

    logic rd_last;
    logic tmo_last;

    assign rd_last  = (rd_cnt_q == RdLast);
    assign tmo_last = (tmo_cnt_q == TmoLast);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid) state_d = StRead;
            StRead:  if (rd_last) state_d = StStart;
            StStart: state_d = StWait;
            StWait: begin
                // done takes priority over a coincident timeout
                if (alu_done) begin
                    state_d = wb_q ? StWrite : StResp;
                end else if (tmo_last) begin
                    state_d = StResp;
                end
            end
            StWrite: state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            opr_q      <= '0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dst_q      <= '0;
            wb_q       <= 1'b0;
            rd_cnt_q   <= '0;
            tmo_cnt_q  <= '0;
            in_a_q     <= '0;
            in_b_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        opr_q    <= cmd_opr;
                        src_a_q  <= cmd_srcA;
                        src_b_q  <= cmd_srcB;
                        dst_q    <= cmd_dst;
                        wb_q     <= cmd_wb;
                        rd_cnt_q <= '0;
                    end
                end
                StRead: begin
                    if (rd_last) begin
                        in_a_q <= outA;
                        in_b_q <= outB;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 3'd1;
                    end
                end
                StStart: tmo_cnt_q <= '0;
                StWait: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    if (alu_done) begin
                        rsp_data_q <= alu_out;
                        rsp_err_q  <= 1'b0;
                    end else if (tmo_last) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state_q == StIdle);

    // Selects hold their last value once READ is over; only the enables drop.
    assign seloutA = src_a_q;
    assign seloutB = src_b_q;
    assign enrregA = (state_q == StRead);
    assign enrregB = (state_q == StRead);
    assign cnstA   = 1'b0;
    assign cnstB   = 1'b0;

    assign regwen  = (state_q == StWrite);
    assign selwreg = (state_q == StWrite) ? dst_q : 4'd0;
    assign endwreg = 2'b00;
    assign wdata   = (state_q == StWrite) ? rsp_data_q : '0;

    assign alu_inA   = in_a_q;
    assign alu_inB   = in_b_q;
    assign alu_opr   = opr_q;
    assign alu_start = (state_q == StStart);

    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alux_sequencer.sv
// Directed, table-driven bench for alux_sequencer with a behavioural reg_bank and ALUX.
module tb_alux_sequencer;

    localparam int unsigned DW = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_wb;
    logic [3:0]    cmd_opr, cmd_srcA, cmd_srcB, cmd_dst;
    logic [3:0]    seloutA, seloutB, selwreg, alu_opr;
    logic          enrregA, enrregB, cnstA, cnstB, regwen, alu_start, alu_done;
    logic [1:0]    endwreg;
    logic [DW-1:0] outA, outB, wdata, alu_inA, alu_inB, alu_out, rsp_data;
    logic          rsp_valid, rsp_ready, rsp_err;

    always #5 clock = ~clock;

    alux_sequencer #(.DATA_W(DW), .RD_LAT(1), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opr(cmd_opr),
        .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB), .cmd_dst(cmd_dst), .cmd_wb(cmd_wb),
        .seloutA(seloutA), .seloutB(seloutB), .enrregA(enrregA), .enrregB(enrregB),
        .cnstA(cnstA), .cnstB(cnstB), .outA(outA), .outB(outB),
        .regwen(regwen), .selwreg(selwreg), .endwreg(endwreg), .wdata(wdata),
        .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_opr(alu_opr), .alu_start(alu_start),
        .alu_out(alu_out), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // reg_bank model: RD_LAT=1 means data is valid within the enabled cycle
    logic [DW-1:0] regs [16];
    logic          pre_we;
    logic [3:0]    pre_sel;
    logic [DW-1:0] pre_data;

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (regwen) begin
            regs[selwreg] <= wdata;
        end else if (pre_we) begin
            regs[pre_sel] <= pre_data;
        end
    end

    assign outA = enrregA ? regs[seloutA] : 64'hBAD0_BAD0_BAD0_BAD0;
    assign outB = enrregB ? regs[seloutB] : 64'hBAD1_BAD1_BAD1_BAD1;

    // ALUX model: done asserted in the Nth WAIT cycle after start (N=0: never)
    int         done_delay;
    logic       force_done;
    logic [3:0] wcnt;

    function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            default: return '0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (!reset) wcnt <= '0;
        else if (alu_start) wcnt <= done_delay[3:0];
        else if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
    end

    assign alu_done = (wcnt == 4'd1) || force_done;
    assign alu_out  = alu_done ? alu_f(alu_opr, alu_inA, alu_inB) : 64'hDEAD_BEEF_DEAD_BEEF;

    typedef struct packed {
        logic [3:0]    opr;
        logic [3:0]    sa;
        logic [3:0]    sb;
        logic [3:0]    dst;
        logic          wb;
        int            nd;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        int            exp_lat;
        int            exp_wen;
    } vec_t;

    vec_t          vt [6];
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_wen, n_start, cyc;
    logic [3:0]    last_sel;
    logic [DW-1:0] last_wd, cap_a, cap_b;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Records per-cycle events of the current cycle, then advances one clock.
    task automatic tick();
        if (regwen) begin
            n_wen++;
            last_sel = selwreg;
            last_wd  = wdata;
        end
        if (alu_start) begin
            n_start++;
            cap_a = alu_inA;
            cap_b = alu_inB;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [3:0] sel, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_sel = sel; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 50) begin tick(); k++; end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    endtask

    // Issue a command; on return cyc is the cycle (1 = first after accept) rsp_valid was seen.
    task automatic issue(input vec_t v, input logic rr);
        wait_ready();
        cmd_opr = v.opr; cmd_srcA = v.sa; cmd_srcB = v.sb; cmd_dst = v.dst; cmd_wb = v.wb;
        done_delay = v.nd; rsp_ready = rr; cmd_valid = 1'b1;
        n_wen = 0; n_start = 0;
        tick();
        cmd_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 60) begin tick(); cyc++; end
    endtask

    task automatic run_vec(input int i);
        vec_t v = vt[i];
        issue(v, 1'b1);
        chk($sformatf("v%0d_latency", i), 64'(cyc), 64'(v.exp_lat));
        chk($sformatf("v%0d_rsp_data", i), rsp_data, v.exp_data);
        chk($sformatf("v%0d_rsp_err", i), 64'(rsp_err), 64'(v.exp_err));
        chk($sformatf("v%0d_cmd_ready_resp", i), 64'(cmd_ready), 64'd0);
        chk($sformatf("v%0d_alu_inA", i), cap_a, v.exp_a);
        chk($sformatf("v%0d_alu_inB", i), cap_b, v.exp_b);
        chk($sformatf("v%0d_start_pulses", i), 64'(n_start), 64'd1);
        chk($sformatf("v%0d_regwen_pulses", i), 64'(n_wen), 64'(v.exp_wen));
        if (v.exp_wen != 0) begin
            chk($sformatf("v%0d_selwreg", i), 64'(last_sel), 64'(v.dst));
            chk($sformatf("v%0d_wdata", i), last_wd, v.exp_data);
            chk($sformatf("v%0d_reg_dst", i), regs[v.dst], v.exp_data);
        end
        tick();
        chk($sformatf("v%0d_rsp_valid_drop", i), 64'(rsp_valid), 64'd0);
        chk($sformatf("v%0d_cmd_ready_after", i), 64'(cmd_ready), 64'd1);
    endtask

    logic [31:0] ctl_bus;
    assign ctl_bus = {enrregA, enrregB, alu_start, rsp_valid, rsp_err, regwen, cnstA, cnstB,
                      seloutA, seloutB, alu_opr, selwreg, endwreg, 6'd0};

    initial begin
        //                opr    sa     sb     dst    wb  nd  exp_a   exp_b   data    err lat wen
        vt[0] = '{4'd2, 4'd3, 4'd4, 4'd7, 1'b1, 2, 64'h10, 64'h5, 64'h15, 1'b0, 6, 1};
        vt[1] = '{4'd3, 4'd2, 4'd2, 4'd0, 1'b0, 2, '1, '1, 64'h0, 1'b0, 5, 0};
        vt[2] = '{4'd2, 4'd3, 4'd4, 4'd5, 1'b1, 0, 64'h10, 64'h5, 64'h0, 1'b1, 11, 0};
        vt[3] = '{4'd2, 4'd7, 4'd4, 4'd7, 1'b1, 1, 64'h15, 64'h5, 64'h1A, 1'b0, 5, 1};
        vt[4] = '{4'd3, 4'd7, 4'd3, 4'd3, 1'b1, 3, 64'h1A, 64'h10, 64'h0A, 1'b0, 7, 1};
        vt[5] = '{4'd2, 4'd4, 4'd4, 4'd1, 1'b0, 8, 64'h5, 64'h5, 64'h0A, 1'b0, 11, 0};

        reset = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b1; force_done = 1'b0; pre_we = 1'b0;
        pre_sel = '0; pre_data = '0; done_delay = 1; n_wen = 0; n_start = 0;
        cmd_opr = 4'd2; cmd_srcA = 4'd3; cmd_srcB = 4'd4; cmd_dst = 4'd7; cmd_wb = 1'b1;

        // Reset held for two edges with cmd_valid high
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset_ctl_zero", 64'(ctl_bus), 64'd0);
            chk("reset_data_zero", alu_inA | alu_inB | rsp_data | wdata, 64'd0);
            chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        end
        reset = 1'b1;
        tick();
        chk("first_edge_read", 64'(enrregA), 64'd1);
        chk("first_edge_ready", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b0;
        wait_ready();

        preload(4'd2, '1);
        preload(4'd3, 64'h10);
        preload(4'd4, 64'h5);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Back-pressure: response must hold while rsp_ready stays low
        issue(vt[5], 1'b0);
        chk("bp_latency_nd8", 64'(cyc), 64'd11);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_data", rsp_data, 64'h0A);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(rsp_valid), 64'd0);
        chk("bp_release_ready", 64'(cmd_ready), 64'd1);

        // Reset during WAIT, then a stray done
        issue_no_wait();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_wait_ready", 64'(cmd_ready), 64'd1);
        chk("rst_wait_valid", 64'(rsp_valid), 64'd0);
        chk("rst_wait_regwen", 64'(regwen), 64'd0);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_done_ready", 64'(cmd_ready), 64'd1);
            chk("late_done_valid", 64'(rsp_valid | rsp_err), 64'd0);
            tick();
        end
        chk("rst_wait_no_wen", 64'(n_wen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Launches a never-completing op and leaves it in its second WAIT cycle.
    task automatic issue_no_wait();
        wait_ready();
        cmd_opr = 4'd2; cmd_srcA = 4'd3; cmd_srcB = 4'd4; cmd_dst = 4'd9; cmd_wb = 1'b1;
        done_delay = 0; rsp_ready = 1'b1; cmd_valid = 1'b1; n_wen = 0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("in_wait_no_start", 64'(alu_start | rsp_valid | enrregA), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

endmodule
